// File: rtl/excess3_serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// excess3_pkg
// Shared definitions for the excess-3 serial transmitter:
//   state_e         FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   EXCESS3_OFFSET  value added to a BCD digit to form its excess-3 code
//   FRAME_BITS      serial bits per frame (start + 4 code + parity + stop)
//   BCD_MAX         largest legal BCD digit
//   excess3_encode  BCD digit -> 4-bit excess-3 code
//   frame_parity    parity bit over the 4 code bits, even or odd sense
// ---------------------------------------------------------------------------
package excess3_pkg;

  typedef enum logic [2:0] {
    IDLE_E   = 3'd0,
    START_E  = 3'd1,
    DATA_E   = 3'd2,
    PARITY_E = 3'd3,
    STOP_E   = 3'd4
  } state_e;

  localparam int EXCESS3_OFFSET = 3;
  localparam int FRAME_BITS     = 7;
  localparam int BCD_MAX        = 9;

  function automatic logic [3:0] excess3_encode(input logic [3:0] bcd);
    return bcd + 4'(EXCESS3_OFFSET);
  endfunction

  function automatic logic frame_parity(input logic [3:0] code, input logic odd);
    return odd ? ~^code : ^code;
  endfunction

endpackage

// File: rtl/excess3_serial_tx_if.sv
// ---------------------------------------------------------------------------
// excess3_serial_tx_if
// Digit handshake and serial-line bundle of the excess-3 transmitter.
//   bcd_in    BCD digit offered by the producer
//   in_valid  bcd_in is valid this cycle
//   in_ready  transmitter accepts a digit this cycle
//   tx_out    serial line, idle high
//   tx_busy   a frame is in progress
//   bcd_err   one-cycle pulse: offered digit was not legal BCD
// Modports: master = producer/observer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface excess3_serial_tx_if;

  logic [3:0] bcd_in;
  logic       in_valid;
  logic       in_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       bcd_err;

  modport master (
    output bcd_in,
    output in_valid,
    input  in_ready,
    input  tx_out,
    input  tx_busy,
    input  bcd_err
  );

  modport slave (
    input  bcd_in,
    input  in_valid,
    output in_ready,
    output tx_out,
    output tx_busy,
    output bcd_err
  );

endinterface

// File: rtl/excess3_serial_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
// Produces a one-cycle tick every DIV enabled cycles; restart clears the
// count so the first tick lands exactly DIV cycles after the restart edge.
//   clk      clock
//   rst_n    asynchronous active-low reset
//   restart  clear the count (frame start)
//   enable   count while a frame is in progress
//   tick     last cycle of the current bit period
// ---------------------------------------------------------------------------
module bit_timer #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  logic [15:0] count_reg;

  assign tick = enable && (count_reg == 16'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 16'd0;
    end else if (restart) begin
      count_reg <= 16'd0;
    end else if (enable) begin
      count_reg <= tick ? 16'd0 : count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/excess3_serial_tx.sv
// ---------------------------------------------------------------------------
// excess3_serial_tx
// Accepts a BCD digit, converts it to excess-3 and sends a 7-bit frame
// LSB first: start(0), code[0..3], parity, stop(1). Each bit lasts DIV
// clocks. Illegal digits (10..15) are refused with a one-cycle bcd_err.
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    excess3_serial_tx_if.slave (digit handshake + serial outputs)
// Parameters: DIV (clocks per bit), PARITY_ODD (0 even, 1 odd).
// ---------------------------------------------------------------------------
module excess3_serial_tx
  import excess3_pkg::*;
#(
  parameter int unsigned DIV        = 4,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  excess3_serial_tx_if.slave   bus
);

  localparam logic [2:0] IDLE   = IDLE_E;
  localparam logic [2:0] START  = START_E;
  localparam logic [2:0] DATA   = DATA_E;
  localparam logic [2:0] PARITY = PARITY_E;
  localparam logic [2:0] STOP   = STOP_E;

  // Frame = start + data + parity + stop
  localparam int         DATA_BITS = FRAME_BITS - 3;
  localparam logic [1:0] LAST_IDX  = 2'(DATA_BITS - 1);

  logic [2:0] state_reg, state_next;
  logic [3:0] shift_reg;
  logic       parity_reg;
  logic [1:0] bit_idx_reg;
  logic       tx_out_reg, tx_busy_reg, in_ready_reg, bcd_err_reg;
  logic       accept, legal, start, tick;
  logic [3:0] code;

  // Handshake uses the registered ready, so nothing is taken in the
  // cycle right after reset release.
  assign accept = (state_reg == IDLE) && in_ready_reg && bus.in_valid;
  assign legal  = (bus.bcd_in <= 4'(BCD_MAX));
  assign start  = accept && legal;
  assign code   = excess3_encode(bus.bcd_in);

  bit_timer #(.DIV(DIV)) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start),
    .enable  (state_reg != IDLE),
    .tick    (tick)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && bit_idx_reg == LAST_IDX) state_next = PARITY;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= 4'd0;
      parity_reg   <= 1'b0;
      bit_idx_reg  <= 2'd0;
      tx_out_reg   <= 1'b1;
      tx_busy_reg  <= 1'b0;
      in_ready_reg <= 1'b0;
      bcd_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // Status outputs are decoded from the next state so they line up
      // with the registered state rather than lagging it by a cycle.
      tx_busy_reg  <= (state_next != IDLE);
      in_ready_reg <= (state_next == IDLE);
      bcd_err_reg  <= accept && !legal;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg   <= code;
            parity_reg  <= frame_parity(code, PARITY_ODD);
            bit_idx_reg <= 2'd0;
            tx_out_reg  <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            tx_out_reg <= shift_reg[0];
            shift_reg  <= {1'b0, shift_reg[3:1]};
          end
        end
        DATA: begin
          if (tick) begin
            bit_idx_reg <= bit_idx_reg + 2'd1;
            if (bit_idx_reg == LAST_IDX) begin
              tx_out_reg <= parity_reg;
            end else begin
              tx_out_reg <= shift_reg[0];
              shift_reg  <= {1'b0, shift_reg[3:1]};
            end
          end
        end
        PARITY: begin
          if (tick) tx_out_reg <= 1'b1;
        end
        default: begin
          // STOP and unused encodings keep the line high
          tx_out_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_out   = tx_out_reg;
  assign bus.tx_busy  = tx_busy_reg;
  assign bus.in_ready = in_ready_reg;
  assign bus.bcd_err  = bcd_err_reg;

endmodule

// File: doc/excess3_serial_tx.md
EXCESS3_SERIAL_TX -- requirements
Module: excess3_serial_tx

Interface
REQ-001 Parameter: DIV, default 4, clock cycles per serial bit period (legal range 1..65535).
REQ-002 Parameter: PARITY_ODD, default 0, parity sense (0 = even, 1 = odd) over the 4 code bits.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: bcd_in  input  4  BCD digit to encode and transmit.
REQ-006 Port: in_valid  input  1  bcd_in is valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts a digit this cycle.
REQ-008 Port: tx_out  output  1  serial line, idle high.
REQ-009 Port: tx_busy  output  1  a frame is in progress.
REQ-010 Port: bcd_err  output  1  one-cycle pulse: offered digit was not legal BCD.

Function
REQ-011 Encoding SHALL be excess-3: code = bcd_in + 3, 4-bit result, computed on the accepted digit only.
REQ-012 Frame SHALL be 7 bits: start (0), code[0], code[1], code[2], code[3], parity, stop (1); LSB first.
REQ-013 Parity bit SHALL be ^code when PARITY_ODD=0, ~^code when PARITY_ODD=1.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 in_ready SHALL be 1 only in IDLE; the handshake completes when in_valid && in_ready at a rising edge.
REQ-016 Accepted legal digit (0..9): FSM moves IDLE->START; tx_out = 0 from the next cycle.
REQ-017 Each frame bit SHALL be held on tx_out for exactly DIV cycles; a full frame occupies 7*DIV cycles.
REQ-018 DATA SHALL hold 4 bit periods, with a 2-bit index from 0 to 3; then PARITY for 1 period, STOP for 1 period, then IDLE.
REQ-019 Between frames the block SHALL spend at least 1 cycle in IDLE with tx_out = 1.
REQ-020 Offered illegal digit (10..15) with in_valid in IDLE: no frame; bcd_err = 1 for exactly that next cycle; FSM stays in IDLE; tx_out stays 1.
REQ-021 Code and parity SHALL be registered at acceptance; changes on bcd_in/in_valid during a frame SHALL have no effect.
REQ-022 tx_busy SHALL be 1 in every state except IDLE.
REQ-023 in_valid while busy SHALL be ignored; no queueing, no error.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to tx_out.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, tx_out 1, tx_busy 0, bcd_err 0, in_ready 0 while rst_n low, bit and divider counters 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; the line returns to 1 without any stop-bit timing.
REQ-027 in_ready SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-028 A shared package excess3_pkg SHALL hold the FSM state enum, EXCESS3_OFFSET = 3, FRAME_BITS = 7, and BCD_MAX = 9.
REQ-029 A single sub-module bit_timer SHALL generate a one-cycle tick every DIV cycles.
REQ-030 bit_timer SHALL restart on a start request.
REQ-031 The top level SHALL contain the FSM, the shift register, and parity generation.

Verification
REQ-032 DIV=4, even parity, bcd_in=5 -> code 1000; tx_out = 0,0,0,0,1,1,1, each bit held 4 cycles; tx_busy high for 28 cycles.
REQ-033 bcd_in=0 -> code 0011; line = 0,1,1,0,0,0,1.
REQ-034 bcd_in=9 -> code 1100; line = 0,0,0,1,1,0,1.
REQ-035 PARITY_ODD=1, bcd_in=9 -> parity bit 1.
REQ-036 bcd_in=12 with in_valid -> bcd_err pulses 1 cycle; tx_out stays 1; in_ready stays 1; tx_busy stays 0.
REQ-037 Back-to-back: in_valid held high with digits 3 then 7 -> two complete frames (codes 0110 and 1010) with at least 1 idle cycle between them.
REQ-038 in_valid pulses mid-frame are ignored.
REQ-039 rst_n pulled low during DATA -> tx_out = 1 and tx_busy = 0 immediately; a clean frame follows after release.
